// File: rtl/sfx_pkg.sv
// sfx_pkg: shared FSM/effect types and default effect tables for sfx_scheduler.
package sfx_pkg;
   typedef enum logic [2:0] {IDLE, WAIT, FETCH, LATCH, PRESENT} state_t;
   typedef enum logic [1:0] {SFX_NONE = 2'b00, SFX_SHOT = 2'b01, SFX_BOOM = 2'b10} sfx_id_t;
   localparam int NUM_SFX = 2;
   localparam int DEF_BASE [NUM_SFX] = '{0, 4096};
   localparam int DEF_LEN  [NUM_SFX] = '{4000, 8000};
endpackage

// File: rtl/sfx_tick_gen.sv
// sfx_tick_gen: free-running sample-rate divider; tick pulses for one cycle after each wrap to 0.
module sfx_tick_gen #(
   parameter int TICK_DIV = 1042
) (
   input  logic clk,
   input  logic reset,
   output logic tick_o
);
   localparam int CW = $clog2(TICK_DIV);
   logic [CW-1:0] cnt_q;
   logic          tick_q;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= (cnt_q == CW'(TICK_DIV - 1)) ? '0 : cnt_q + 1'b1;
         tick_q <= cnt_q == CW'(TICK_DIV - 1);
      end
   assign tick_o = tick_q;
endmodule

// File: rtl/sfx_scheduler.sv
// sfx_scheduler: arbitrates two sound effects and streams one ROM sample per tick to the codec.
// Optional SFX_ATTEN_EN adds an atten input that arithmetically right-shifts fetched samples.
module sfx_scheduler
   import sfx_pkg::*;
#(
   parameter int ADDR_W    = 14,
   parameter int SAMPLE_W  = 16,
   parameter int SFX0_BASE = DEF_BASE[0],
   parameter int SFX0_LEN  = DEF_LEN[0],
   parameter int SFX1_BASE = DEF_BASE[1],
   parameter int SFX1_LEN  = DEF_LEN[1],
   parameter int TICK_DIV  = 1042
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [1:0]          sfx_req,
`ifdef SFX_ATTEN_EN
   input  logic [1:0]          atten,
`endif
   output logic [ADDR_W-1:0]   rom_addr,
   output logic                rom_rd,
   input  logic [SAMPLE_W-1:0] rom_data,
   output logic [SAMPLE_W-1:0] sample_data,
   output logic                sample_valid,
   input  logic                sample_ready,
   output logic                busy,
   output logic [1:0]          active_sfx,
   output logic [7:0]          missed_ticks
);
   localparam int MAX_LEN = SFX0_LEN > SFX1_LEN ? SFX0_LEN : SFX1_LEN;
   localparam int REM_W   = $clog2(MAX_LEN + 1);
   state_t              state_q;
   sfx_id_t             active_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [REM_W-1:0]    rem_q;
   logic [SAMPLE_W-1:0] sample_q, fetched;
   logic                valid_q, rd_q, busy_q;
   logic [7:0]          missed_q;
   logic [1:0]          req_q, pend_q, pend_d, trig;
   logic                tick, arb, start0, start1, start;

   sfx_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (.clk(clk), .reset(reset), .tick_o(tick));

`ifdef SFX_ATTEN_EN
   assign fetched = SAMPLE_W'($signed(rom_data) >>> atten);
`else
   assign fetched = rom_data;
`endif

   // A preempted shot is re-queued so it replays from its base once the explosion ends.
   always_comb begin
      trig   = sfx_req & ~req_q;
      arb    = state_q == IDLE || state_q == WAIT;
      start1 = arb & pend_q[1];
      start0 = arb & ~pend_q[1] & pend_q[0] & ~active_q[1];
      start  = start1 | start0;
      pend_d = (pend_q & ~{start1, start0}) | trig | {1'b0, start1 & active_q[0]};
   end

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state_q  <= IDLE;
         active_q <= SFX_NONE;
         addr_q   <= '0;
         rem_q    <= '0;
         sample_q <= '0;
         valid_q  <= 1'b0;
         rd_q     <= 1'b0;
         busy_q   <= 1'b0;
         missed_q <= '0;
         req_q    <= '0;
         pend_q   <= '0;
      end else begin
         req_q  <= sfx_req;
         pend_q <= pend_d;
         rd_q   <= 1'b0;
         if (tick && state_q == PRESENT) missed_q <= missed_q + 8'(missed_q != 8'hff);
         if (start) begin
            active_q <= start1 ? SFX_BOOM : SFX_SHOT;
            busy_q   <= 1'b1;
            addr_q   <= start1 ? ADDR_W'(SFX1_BASE) : ADDR_W'(SFX0_BASE);
            rem_q    <= start1 ? REM_W'(SFX1_LEN) : REM_W'(SFX0_LEN);
            state_q  <= tick ? FETCH : WAIT;
            rd_q     <= tick;
         end else
            case (state_q)
               IDLE:
                  if (tick) begin
                     sample_q <= '0;
                     valid_q  <= 1'b1;
                     state_q  <= PRESENT;
                  end
               WAIT:
                  if (tick) begin
                     state_q <= FETCH;
                     rd_q    <= 1'b1;
                  end
               FETCH: state_q <= LATCH;
               LATCH: begin
                  sample_q <= fetched;
                  valid_q  <= 1'b1;
                  addr_q   <= addr_q + 1'b1;
                  rem_q    <= rem_q - 1'b1;
                  state_q  <= PRESENT;
               end
               PRESENT:
                  if (sample_ready) begin
                     valid_q <= 1'b0;
                     if (rem_q == '0) begin
                        busy_q   <= 1'b0;
                        active_q <= SFX_NONE;
                        state_q  <= (|pend_q) ? WAIT : IDLE;
                     end else
                        state_q <= WAIT;
                  end
               default: state_q <= IDLE;
            endcase
      end

   assign rom_addr     = addr_q;
   assign rom_rd       = rd_q;
   assign sample_data  = sample_q;
   assign sample_valid = valid_q;
   assign busy         = busy_q;
   assign active_sfx   = active_q;
   assign missed_ticks = missed_q;
endmodule

// File: tb/tb_sfx_scheduler.sv
// tb_sfx_scheduler: scoreboard bench; a sample-stream reference model predicts every accepted sample.
module tb_sfx_scheduler;
   localparam int ADDR_W = 14, SAMPLE_W = 16, TD = 8;
   localparam int BASE0 = 0, LEN0 = 4, BASE1 = 4096, LEN1 = 3;

   logic                clk = 1'b0, reset = 1'b1, rom_rd, sample_valid, busy;
   logic                sample_ready = 1'b1;
   logic [1:0]          sfx_req = 2'b00, active_sfx;
   logic [ADDR_W-1:0]   rom_addr;
   logic [SAMPLE_W-1:0] rom_data = '0, sample_data;
   logic [7:0]          missed_ticks;
   int                  checks = 0, passes = 0;

   logic [15:0] exp_q[$];
   int          cur = -1, pos = 0, missed_m = 0, stall_left = 0;
   logic [1:0]  pend_m = 2'b00, req_m = 2'b00;
   bit          fx;

   always #5 clk = ~clk;

   sfx_scheduler #(
      .ADDR_W(ADDR_W), .SAMPLE_W(SAMPLE_W), .SFX0_BASE(BASE0), .SFX0_LEN(LEN0),
      .SFX1_BASE(BASE1), .SFX1_LEN(LEN1), .TICK_DIV(TD)
   ) dut (
      .clk(clk), .reset(reset), .sfx_req(sfx_req),
`ifdef SFX_ATTEN_EN
      .atten(2'b00),
`endif
      .rom_addr(rom_addr), .rom_rd(rom_rd), .rom_data(rom_data), .sample_data(sample_data),
      .sample_valid(sample_valid), .sample_ready(sample_ready), .busy(busy),
      .active_sfx(active_sfx), .missed_ticks(missed_ticks)
   );

   function automatic logic [15:0] rom_val(input int a);
      return 16'(a * 37 + 'h8005);
   endfunction

   always @(posedge clk) if (rom_rd) rom_data <= rom_val(int'(rom_addr));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Reference model: which effect plays, how far in, and which requests wait.
   function automatic int base_of(input int e); return e == 1 ? BASE1 : BASE0; endfunction
   function automatic int len_of(input int e);  return e == 1 ? LEN1 : LEN0;   endfunction
   function automatic logic [1:0] act_m(); return cur < 0 ? 2'b00 : (cur == 1 ? 2'b10 : 2'b01); endfunction

   task automatic resolve();
      if (pend_m[1]) begin
         if (cur == 0) pend_m[0] = 1'b1;
         cur = 1; pos = 0; pend_m[1] = 1'b0;
      end else if (pend_m[0] && cur != 1) begin
         cur = 0; pos = 0; pend_m[0] = 1'b0;
      end
   endtask

   task automatic emit();
      fx = cur >= 0;
      if (!fx) exp_q.push_back(16'h0);
      else begin
         exp_q.push_back(rom_val(base_of(cur) + pos));
         pos++;
         if (pos == len_of(cur)) begin cur = -1; resolve(); end
      end
   endtask

   task automatic set_req(input logic [1:0] v);
      pend_m |= v & ~req_m;
      req_m = v;
      sfx_req = v;
      resolve();
   endtask

   function automatic logic [1:0] rand_req();
      logic [1:0] v = req_m;
      for (int i = 0; i < 2; i++) if ($urandom_range(0, 3) == 0) v[i] = ~v[i];
      return v;
   endfunction

   task automatic edges(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   // Starts on the negedge inside a tick cycle, ends on the negedge inside the next one.
   task automatic period(input int stall, input int nreq);
      bit emitted;
      emitted = 1'b0;
      if (stall_left == 0) begin
         emit();
         emitted = fx;
         if (stall > 0) begin sample_ready = 1'b0; stall_left = stall; end
         edges(2);
         if (emitted && sample_ready) chk("early_valid", sample_valid, 1'b0);
         edges(1);
         if (emitted && sample_ready) chk("latency", sample_valid, 1'b1);
      end else begin
         stall_left--;
         missed_m = missed_m < 255 ? missed_m + 1 : 255;
         if (stall_left == 0) begin edges(1); sample_ready = 1'b1; edges(2); end
         else edges(3);
      end
      edges(1);
      if (sample_ready) set_req(nreq < 0 ? rand_req() : 2'(nreq));
      edges(3);
      if (sample_ready) begin
         chk("active_sfx", active_sfx, act_m());
         chk("busy", busy, cur >= 0);
      end
      edges(1);
   endtask

   task automatic chk_zero_outputs();
      chk("rst_addr", rom_addr, 0);
      chk("rst_rd", rom_rd, 0);
      chk("rst_data", sample_data, 0);
      chk("rst_valid", sample_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_active", active_sfx, 0);
      chk("rst_missed", missed_ticks, 0);
   endtask

   initial forever begin
      @(negedge clk); #1;
      if (!reset && sample_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL sample: valid with nothing expected, got %0h", sample_data);
         end else begin
            chk("sample", sample_data, exp_q[0]);
            if (sample_ready) void'(exp_q.pop_front());
         end
      end
   end

   int dir [22][2] = '{'{0,0}, '{0,0}, '{0,1}, '{0,1}, '{0,3}, '{0,3}, '{0,3}, '{0,3},
                       '{0,3}, '{0,3}, '{0,3}, '{0,3}, '{0,1}, '{0,3}, '{0,1}, '{0,3},
                       '{0,1}, '{3,1}, '{0,1}, '{0,1}, '{0,1}, '{0,1}};

   initial begin
      edges(3);
      chk_zero_outputs();
      reset = 1'b0;
      edges(TD);
      foreach (dir[i]) period(dir[i][0], dir[i][1]);
      chk("missed_stall3", missed_ticks, missed_m);
      for (int i = 0; i < 250; i++)
         period($urandom_range(0, 15) == 0 ? $urandom_range(1, 3) : 0, -1);
      period(260, -1);
      for (int i = 0; i < 260; i++) period(0, -1);
      chk("missed_sat", missed_ticks, missed_m);
      period(0, 0);
      period(0, 2);
      period(0, 3);
      emit();
      edges(3);
      #2 reset = 1'b1;
      #1 chk_zero_outputs();
      exp_q.delete();
      cur = -1; pos = 0; pend_m = 2'b00; req_m = 2'b00; missed_m = 0; stall_left = 0;
      sfx_req = 2'b00;
      @(negedge clk);
      reset = 1'b0;
      edges(TD);
      for (int i = 0; i < 4; i++) period(0, 0);
      chk("missed_after_rst", missed_ticks, 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
